// File: rtl/tt_response_checker.sv
// tt_response_checker: captures the single-bit response of a DUT over an
// exhaustive counting-order input sweep and compares it with an expected
// truth table. It reports pass/fail, the mismatch count, the first failing
// vector and whether the sweep arrived out of counting order.
module tt_response_checker #(
  parameter int                    N_IN     = 5,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED = 32'hFFFE_8000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [N_IN-1:0]         in_vec,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    order_err,
  output logic [N_IN:0]           mismatch_count,
  output logic [N_IN-1:0]         first_fail_idx,
  output logic [(1<<N_IN)-1:0]    captured
);

  localparam int              DEPTH    = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } state_t;

  state_t          state;
  logic [N_IN-1:0] index;

  logic            miss;
  logic            in_order;
  logic [N_IN:0]   count_next;

  // Per-sample decode: does the arriving vector match the expected order and value.
  always_comb begin
    miss       = (f_in != EXPECTED[index]);
    in_order   = (in_vec == index);
    count_next = mismatch_count + {{N_IN{1'b0}}, miss};
  end

  // Capture FSM; start restarts from any state and beats a coincident sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      index          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      order_err      <= 1'b0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      captured       <= '0;
    end else if (start) begin
      state          <= CAPTURE;
      index          <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      order_err      <= 1'b0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
      captured       <= '0;
    end else begin
      case (state)
        CAPTURE: begin
          if (in_valid) begin
            if (in_order) begin
              captured[index] <= f_in;
              mismatch_count  <= count_next;
              if (miss && (mismatch_count == '0)) begin
                first_fail_idx <= index;
              end
              if (index == LAST_IDX) begin
                state <= DONE;
                index <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
                pass  <= (count_next == '0);
              end else begin
                index <= index + 1'b1;
              end
            end else begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= 1'b0;
              order_err <= 1'b1;
            end
          end
        end
        IDLE, DONE: begin
          state <= state;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tt_response_checker.sv
// tb_tt_response_checker: directed and randomized sweeps of the response
// checker, compared every cycle against a behavioural model of the capture run.
module tb_tt_response_checker;

  localparam int N_IN  = 5;
  localparam int DEPTH = 32;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [N_IN-1:0]   in_vec;
  logic              f_in;
  logic              busy;
  logic              done;
  logic              pass;
  logic              order_err;
  logic [N_IN:0]     mismatch_count;
  logic [N_IN-1:0]   first_fail_idx;
  logic [DEPTH-1:0]  captured;

  logic [DEPTH-1:0]  exp_tab;

  // Behavioural model of one capture run
  int                m_state;      // 0 idle, 1 capturing, 2 finished
  int                m_next;
  int                m_mism;
  int                m_first;
  logic              m_oerr;
  logic [DEPTH-1:0]  m_cap;

  int compare_count;
  int fail_count;

  tt_response_checker #(
    .N_IN     (N_IN),
    .EXPECTED (32'hFFFE_8000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_vec         (in_vec),
    .f_in           (f_in),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .order_err      (order_err),
    .mismatch_count (mismatch_count),
    .first_fail_idx (first_fail_idx),
    .captured       (captured)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_state = 0;
    m_next  = 0;
    m_mism  = 0;
    m_first = 0;
    m_oerr  = 1'b0;
    m_cap   = '0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic [N_IN-1:0] vec, input logic f);
    if (s) begin
      model_reset();
      m_state = 1;
    end else if (m_state == 1 && v) begin
      if (int'(vec) == m_next) begin
        m_cap[m_next] = f;
        if (f != exp_tab[m_next]) begin
          if (m_mism == 0) m_first = m_next;
          m_mism++;
        end
        if (m_next == DEPTH - 1) begin
          m_next  = 0;
          m_state = 2;
        end else begin
          m_next++;
        end
      end else begin
        m_oerr  = 1'b1;
        m_state = 2;
      end
    end
  endtask

  task automatic check_output(input string tag);
    logic             e_busy;
    logic             e_done;
    logic             e_pass;
    logic [N_IN:0]    e_mism;
    logic [N_IN-1:0]  e_first;
    e_busy  = (m_state == 1);
    e_done  = (m_state == 2);
    e_pass  = e_done && !m_oerr && (m_mism == 0);
    e_mism  = (N_IN+1)'(m_mism);
    e_first = N_IN'(m_first);

    compare_count++;
    assert (busy === e_busy) else begin
      fail_count++;
      $error("FAIL %s.busy observed=%0b expected=%0b", tag, busy, e_busy);
    end
    compare_count++;
    assert (done === e_done) else begin
      fail_count++;
      $error("FAIL %s.done observed=%0b expected=%0b", tag, done, e_done);
    end
    compare_count++;
    assert (pass === e_pass) else begin
      fail_count++;
      $error("FAIL %s.pass observed=%0b expected=%0b", tag, pass, e_pass);
    end
    compare_count++;
    assert (order_err === m_oerr) else begin
      fail_count++;
      $error("FAIL %s.order_err observed=%0b expected=%0b", tag, order_err, m_oerr);
    end
    compare_count++;
    assert (mismatch_count === e_mism) else begin
      fail_count++;
      $error("FAIL %s.mismatch_count observed=%0d expected=%0d", tag, mismatch_count, e_mism);
    end
    compare_count++;
    assert (first_fail_idx === e_first) else begin
      fail_count++;
      $error("FAIL %s.first_fail_idx observed=%0d expected=%0d", tag, first_fail_idx, e_first);
    end
    compare_count++;
    assert (captured === m_cap) else begin
      fail_count++;
      $error("FAIL %s.captured observed=%h expected=%h", tag, captured, m_cap);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then check just after the edge
  task automatic apply_stimulus(input string tag, input logic s, input logic v,
                                input logic [N_IN-1:0] vec, input logic f);
    start    = s;
    in_valid = v;
    in_vec   = vec;
    f_in     = f;
    @(posedge clk);
    #1;
    model_step(s, v, vec, f);
    check_output(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      apply_stimulus(tag, 1'b0, 1'b0, N_IN'($urandom), 1'($urandom));
    end
  endtask

  // Directed and randomized scenarios in sequence
  initial begin
    logic [N_IN-1:0] v;
    logic            f;
    compare_count = 0;
    fail_count    = 0;
    exp_tab       = 32'hFFFE_8000;
    model_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_vec   = '0;
    f_in     = 1'b0;
    #12;
    check_output("reset_state");
    reset = 1'b0;
    idle_cycles("idle_after_reset", 2);

    // 1: clean full sweep
    apply_stimulus("t1_start", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = N_IN'(i);
      apply_stimulus("t1_vec", 1'b0, 1'b1, v, exp_tab[i]);
    end
    idle_cycles("t1_done_hold", 2);
    apply_stimulus("t1_ignored_after_done", 1'b0, 1'b1, 5'd0, 1'b0);

    // 2: single mismatch at vector 13
    apply_stimulus("t2_start", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = N_IN'(i);
      f = (i == 13) ? ~exp_tab[i] : exp_tab[i];
      apply_stimulus("t2_vec", 1'b0, 1'b1, v, f);
    end
    idle_cycles("t2_done", 1);

    // 3: order error 0,1,2,4
    apply_stimulus("t3_start", 1'b1, 1'b0, '0, 1'b0);
    apply_stimulus("t3_vec0", 1'b0, 1'b1, 5'd0, 1'b0);
    apply_stimulus("t3_vec1", 1'b0, 1'b1, 5'd1, 1'b0);
    apply_stimulus("t3_vec2", 1'b0, 1'b1, 5'd2, 1'b0);
    apply_stimulus("t3_vec4", 1'b0, 1'b1, 5'd4, 1'b1);
    apply_stimulus("t3_vec3_late", 1'b0, 1'b1, 5'd3, 1'b1);
    idle_cycles("t3_done", 1);

    // 4: three idle cycles between every vector
    apply_stimulus("t4_start", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = N_IN'(i);
      apply_stimulus("t4_vec", 1'b0, 1'b1, v, exp_tab[i]);
      if (i != DEPTH - 1) idle_cycles("t4_gap", 3);
    end
    idle_cycles("t4_done", 1);

    // 5: asynchronous reset mid-sweep, then a clean run
    apply_stimulus("t5_start", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i <= 10; i++) begin
      v = N_IN'(i);
      apply_stimulus("t5_vec", 1'b0, 1'b1, v, ~exp_tab[i]);
    end
    reset = 1'b1;
    #2;
    model_reset();
    check_output("t5_async_reset");
    @(posedge clk);
    #1;
    check_output("t5_reset_held");
    reset = 1'b0;
    apply_stimulus("t5_restart", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = N_IN'(i);
      apply_stimulus("t5_vec_full", 1'b0, 1'b1, v, exp_tab[i]);
    end

    // 6: restart mid-sweep with coincident in_valid, then again with a bad sample
    apply_stimulus("t6_start", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      v = N_IN'(i);
      apply_stimulus("t6_vec", 1'b0, 1'b1, v, ~exp_tab[i]);
    end
    apply_stimulus("t6_start_at_20", 1'b1, 1'b1, 5'd20, exp_tab[20]);
    apply_stimulus("t6_start_with_bad0", 1'b1, 1'b1, 5'd0, ~exp_tab[0]);
    for (int i = 0; i < DEPTH; i++) begin
      v = N_IN'(i);
      apply_stimulus("t6_vec_full", 1'b0, 1'b1, v, exp_tab[i]);
    end

    // every vector wrong: mismatch_count reaches 2^N_IN
    apply_stimulus("all_wrong_start", 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      v = N_IN'(i);
      apply_stimulus("all_wrong_vec", 1'b0, 1'b1, v, ~exp_tab[i]);
    end

    // randomized runs: random gaps, random response errors, rare order slips
    for (int r = 0; r < 6; r++) begin
      apply_stimulus("rnd_start", 1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
        idle_cycles("rnd_gap", int'($urandom_range(0, 2)));
        v = N_IN'(i);
        if ($urandom_range(0, 99) < 2) v = N_IN'(i + 1);
        f = ($urandom_range(0, 3) == 0) ? ~exp_tab[i] : exp_tab[i];
        apply_stimulus("rnd_vec", 1'b0, 1'b1, v, f);
      end
      idle_cycles("rnd_done", 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
